// File: rtl/md_seq_pkg.sv
// Shared constants for the md_seq iterative multiply/divide unit:
// operation encodings and FSM state encodings.
package md_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_MULU = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

endpackage

// File: rtl/md_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MD_SIGNED_EN to add signed MUL/DIV; otherwise req_op[1] is ignored.
module md_seq
   import md_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_lo,
   output logic [WIDTH-1:0] resp_hi,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic             accept;
   logic             is_div;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res_lo, res_hi;

   logic [WIDTH-1:0] in_a, in_b;
   logic [WIDTH:0]   add_x, add_y;
   logic             add_cin;
   logic [WIDTH+1:0] add_full;
   logic             no_borrow;
   logic [WIDTH-1:0] acc_nx, quo_nx;
   logic [WIDTH-1:0] fin_lo, fin_hi;

`ifdef MD_SIGNED_EN
   logic                 sign_a, sign_b;
   logic                 neg_lo, neg_hi;
   logic [2*WIDTH-1:0]   prod_neg;
`else
   logic                 unused_op_sign;
   assign unused_op_sign = req_op[1];
`endif

   assign req_ready  = (state == IDLE) && !kill;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);
   assign resp_lo    = res_lo;
   assign resp_hi    = res_hi;

   // Operands enter the iteration as magnitudes; sign is reapplied at the end.
`ifdef MD_SIGNED_EN
   assign sign_a = req_op[1] & req_a[WIDTH-1];
   assign sign_b = req_op[1] & req_b[WIDTH-1];
   assign in_a   = sign_a ? -req_a : req_a;
   assign in_b   = sign_b ? -req_b : req_b;
`else
   assign in_a = req_a;
   assign in_b = req_b;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = DONE;
         DONE:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (kill) state_nx = IDLE;
   end

   // One shared WIDTH+1-bit adder: add for multiply, subtract for divide.
   always_comb begin
      if (is_div) begin
         add_x   = {acc, quo[WIDTH-1]};
         add_y   = ~{1'b0, opnd};
         add_cin = 1'b1;
      end else begin
         add_x   = {1'b0, acc};
         add_y   = quo[0] ? {1'b0, opnd} : '0;
         add_cin = 1'b0;
      end
      add_full  = {1'b0, add_x} + {1'b0, add_y} + (WIDTH + 2)'(add_cin);
      no_borrow = add_full[WIDTH+1];
      if (is_div) begin
         acc_nx = no_borrow ? add_full[WIDTH-1:0] : add_x[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], no_borrow};
      end else begin
         acc_nx = add_full[WIDTH:1];
         quo_nx = {add_full[0], quo[WIDTH-1:1]};
      end
   end

   always_comb begin
      fin_lo = quo_nx;
      fin_hi = acc_nx;
`ifdef MD_SIGNED_EN
      prod_neg = -{acc_nx, quo_nx};
      if (!is_div && neg_lo) {fin_hi, fin_lo} = prod_neg;
      if (is_div && neg_lo)  fin_lo = -quo_nx;
      if (is_div && neg_hi)  fin_hi = -acc_nx;
`endif
   end

   // Multiply keeps the multiplier in quo; divide shifts the dividend out of quo.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         quo    <= '0;
         cnt    <= '0;
         res_lo <= '0;
         res_hi <= '0;
`ifdef MD_SIGNED_EN
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
`endif
      end else if (accept) begin
         is_div <= req_op[0];
         opnd   <= req_op[0] ? in_b : in_a;
         quo    <= req_op[0] ? in_a : in_b;
         acc    <= '0;
         cnt    <= '0;
`ifdef MD_SIGNED_EN
         neg_lo <= (sign_a ^ sign_b) && !(req_op[0] && (req_b == '0));
         neg_hi <= sign_a;
`endif
      end else if (state == RUN) begin
         acc <= acc_nx;
         quo <= quo_nx;
         cnt <= cnt + CW'(1);
         if (cnt == LAST && !kill) begin
            res_lo <= fin_lo;
            res_hi <= fin_hi;
         end
      end
   end

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: vector table through a scoreboard, plus
// latency, back-pressure, kill and reset sequences. Honours MD_SIGNED_EN.
module tb_md_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [W-1:0]  req_a, req_b;
   logic          kill;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_lo, resp_hi;
   logic          busy;

   typedef struct {
      string        name;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } vec_t;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   checks = 0;
   int   passes = 0;

   md_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_lo(resp_lo), .resp_hi(resp_hi), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic addVec(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
      vecs.push_back(v);
   endtask

   // Presents a request and returns just after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] lo, input logic [W-1:0] hi);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      e.lo = lo; e.hi = hi;
      expQ.push_back(e);
   endtask

   // Waits for a result, compares with the scoreboard head, then takes it.
   task automatic checkOutput(input string name);
      exp_t e;
      int   n = 0;
      while (!resp_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      if (!resp_valid) begin
         check({name, "_timeout"}, 64'(resp_valid), 64'd1);
      end else if (expQ.size() == 0) begin
         check({name, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = expQ.pop_front();
         check({name, "_lo"}, 64'(resp_lo), 64'(e.lo));
         check({name, "_hi"}, 64'(resp_hi), 64'(e.hi));
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   initial begin
      int           cyc;
      bit           stable;
      bit           seen;
      logic [W-1:0] holdLo, holdHi;

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      kill = 1'b0; resp_ready = 1'b0;

      addVec("mulu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
      addVec("mulu_small", 2'b00, 32'd12345,    32'd6789,     32'd83810205,  32'd0);
      addVec("mulu_carry", 2'b00, 32'h80000000, 32'd2,        32'd0,         32'd1);
      addVec("mulu_zero",  2'b00, 32'd0,        32'hDEADBEEF, 32'd0,         32'd0);
      addVec("divu_100_7", 2'b01, 32'd100,      32'd7,        32'd14,        32'd2);
      addVec("divu_by0",   2'b01, 32'd5,        32'd0,        32'hFFFFFFFF,  32'd5);
      addVec("divu_by1",   2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  32'd0);
      addVec("divu_small", 2'b01, 32'd3,        32'd10,       32'd0,         32'd3);
      addVec("divu_eq",    2'b01, 32'h80000000, 32'h80000000, 32'd1,         32'd0);
`ifdef MD_SIGNED_EN
      addVec("mul_m3x5",   2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  32'hFFFFFFFF);
      addVec("mul_negneg", 2'b10, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'd24,        32'd0);
      addVec("div_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF);
      addVec("div_7_m2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1);
      addVec("div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  32'd0);
      addVec("div_m7_0",   2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF,  32'hFFFFFFF9);
`else
      addVec("div_as_divu", 2'b11, 32'hFFFFFFF9, 32'd2,       32'h7FFFFFFC,  32'd1);
      addVec("mul_as_mulu", 2'b10, 32'hFFFFFFFD, 32'd5,       32'hFFFFFFF1,  32'd4);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_lo_hi",      {resp_hi, resp_lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle_req_ready", 64'(req_ready), 64'd1);

      // Latency, then ten cycles of back-pressure in DONE.
      applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
      cyc = 1;
      while (!resp_valid && cyc < 200) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("latency", 64'(cyc), 64'(W + 1));
      holdLo = resp_lo; holdHi = resp_hi;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!resp_valid || req_ready || !busy || resp_lo !== holdLo || resp_hi !== holdHi)
            stable = 1'b0;
      end
      check("done_stall_stable", 64'(stable), 64'd1);
      checkOutput("latency_result");
      check("after_take_ready", {62'd0, req_ready, busy}, {62'd0, 2'b10});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
         checkOutput(vecs[i].name);
      end

      // Kill with a request present in IDLE must not accept.
      @(negedge clk);
      req_valid = 1'b1; kill = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd3;
      #1 check("kill_idle_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 req_valid = 1'b0; kill = 1'b0;
      check("kill_idle_busy", 64'(busy), 64'd0);

      // Kill at RUN cycle 10.
      applyStimulus(2'b01, 32'd1000, 32'd3, 32'd333, 32'd1);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      check("kill_run_busy", {63'd0, busy}, 64'd0);
      void'(expQ.pop_back());
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("kill_no_resp", 64'(seen), 64'd0);

      // Reset at RUN cycle 20 after a nonzero result is showing.
      applyStimulus(2'b01, 32'd100, 32'd7, 32'd14, 32'd2);
      checkOutput("pre_rst_result");
      applyStimulus(2'b00, 32'd9, 32'd9, 32'd81, 32'd0);
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_run_valid_busy", {62'd0, resp_valid, busy}, 64'd0);
      check("rst_run_lo_hi", {resp_hi, resp_lo}, 64'd0);
      void'(expQ.pop_back());
      check("rst_run_ready", 64'(req_ready), 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
